// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and address-split helpers for dcache_dm.
package dcache_pkg;
    localparam int WORD_OFF = 3;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t RD_REQ  = 2'd1;
    localparam state_t RD_WAIT = 2'd2;
    localparam state_t WR_REQ  = 2'd3;
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int idx_w);
        return (addr >> WORD_OFF) & ((64'd1 << idx_w) - 64'd1);
    endfunction
    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w);
        return addr >> (WORD_OFF + idx_w);
    endfunction
endpackage

// File: rtl/dcache_dm_array.sv
// dcache_dm_array: valid/tag/data storage with combinational read, one write port
// and single-cycle invalidate-all.
module dcache_dm_array #(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 61 - IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [63:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [63:0]      wr_data,
    input  logic             inv
);
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [63:0]      data [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     valid <= '0;
        else if (inv)   valid <= '0;
        else if (wr_en) valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-through, no-write-allocate L1 data cache.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        miss,
    input  logic        inv_all,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int TAG_W = 61 - IDX_W;

    state_t           state;
    logic             wr_hit;
    logic [IDX_W-1:0] req_idx, lat_idx;
    logic [TAG_W-1:0] req_tag, lat_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [63:0]      rd_data;
    logic             accept, hit, rd_hit, fill, wr_done, hit_inc, miss_inc;

    assign req_idx  = IDX_W'(addr_index(req_addr, IDX_W));
    assign req_tag  = TAG_W'(addr_tag(req_addr, IDX_W));
    // mem_req_addr doubles as the latched transaction address
    assign lat_idx  = IDX_W'(addr_index(mem_req_addr, IDX_W));
    assign lat_tag  = TAG_W'(addr_tag(mem_req_addr, IDX_W));

    assign req_ready     = (state == IDLE) && !inv_all;
    assign mem_req_valid = (state == RD_REQ) || (state == WR_REQ);
    assign accept   = (req_read || req_write) && req_ready;
    assign hit      = rd_valid && (rd_tag == req_tag);
    assign rd_hit   = accept && !req_write && hit;
    assign fill     = (state == RD_WAIT) && mem_resp_valid;
    assign wr_done  = (state == WR_REQ) && mem_req_ready;
    assign hit_inc  = rd_hit || (wr_done && wr_hit);
    assign miss_inc = fill || (wr_done && !wr_hit);

    dcache_dm_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill || (accept && req_write && hit)),
        .wr_idx   (fill ? lat_idx : req_idx),
        .wr_tag   (fill ? lat_tag : req_tag),
        .wr_data  (fill ? mem_resp_rdata : req_wdata),
        .inv      (inv_all && (state == IDLE))
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_hit        <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            miss          <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            state <= accept ? (req_write ? WR_REQ : (hit ? IDLE : RD_REQ)) :
                     (state == RD_REQ && mem_req_ready) ? RD_WAIT :
                     (fill || wr_done) ? IDLE : state;
            if (accept) begin
                mem_req_addr  <= {req_addr[63:3], 3'b000};
                mem_req_wdata <= req_wdata;
                mem_req_we    <= req_write;
                wr_hit        <= hit;
            end
            resp_valid <= rd_hit || fill || wr_done;
            if (rd_hit) begin
                resp_rdata <= rd_data;
                miss       <= 1'b0;
            end else if (fill) begin
                resp_rdata <= mem_resp_rdata;
                miss       <= 1'b1;
            end else if (wr_done) begin
                resp_rdata <= '0;
                miss       <= !wr_hit;
            end
            if (hit_inc && hit_count != '1)   hit_count  <= hit_count + 32'd1;
            if (miss_inc && miss_count != '1) miss_count <= miss_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed plus randomized checks of dcache_dm against a
// transparent-cache reference model (line map + backing memory).
module tb_dcache_dm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, miss;
    logic [63:0] resp_rdata;
    logic        inv_all = 1'b0;
    logic        mem_req_valid, mem_req_we;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = '0;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    logic        mv [16];
    logic [63:0] ma [16];
    logic [63:0] mem [logic [63:0]];
    int          exp_hits = 0;
    int          exp_miss = 0;

    always #5 clk = ~clk;

    dcache_dm dut (
        .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .miss(miss), .inv_all(inv_all),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] al(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

    function automatic int ix(input logic [63:0] a);
        return int'(a[6:3]);
    endfunction

    function automatic bit m_hit(input logic [63:0] a);
        return mv[ix(a)] && ma[ix(a)] == al(a);
    endfunction

    function automatic logic [63:0] mem_rd(input logic [63:0] w);
        if (!mem.exists(w)) mem[w] = {$urandom, $urandom};
        return mem[w];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    task automatic chk_counts();
        chk("hit_count", 64'(hit_count), 64'(exp_hits));
        chk("miss_count", 64'(miss_count), 64'(exp_miss));
    endtask

    task automatic do_read(input logic [63:0] a, input int rdly, input int wdly, input bit inv_wait);
        logic [63:0] w;
        logic [63:0] d;
        bit h;
        w = al(a);
        h = m_hit(a);
        d = mem_rd(w);
        @(negedge clk);
        req_read = 1'b1;
        req_addr = a;
        #1 chk("rd_accept_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_read = 1'b0;
        if (h) begin
            chk("rd_hit_valid", 64'(resp_valid), 64'd1);
            chk("rd_hit_data", resp_rdata, d);
            chk("rd_hit_miss", 64'(miss), 64'd0);
            exp_hits++;
        end else begin
            chk("rd_mreq_valid", 64'(mem_req_valid), 64'd1);
            chk("rd_mreq_addr", mem_req_addr, w);
            chk("rd_mreq_we", 64'(mem_req_we), 64'd0);
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk);
                chk("rd_hold_valid", 64'(mem_req_valid), 64'd1);
                chk("rd_hold_addr", mem_req_addr, w);
                chk("rd_hold_ready", 64'(req_ready), 64'd0);
                chk("rd_hold_resp", 64'(resp_valid), 64'd0);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk("rd_wait_mreq", 64'(mem_req_valid), 64'd0);
            if (inv_wait) inv_all = 1'b1;
            for (int i = 0; i < wdly; i++) begin
                @(negedge clk);
                chk("rd_wait_resp", 64'(resp_valid), 64'd0);
            end
            mem_resp_valid = 1'b1;
            mem_resp_rdata = d;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_rdata = {$urandom, $urandom};
            chk("rd_miss_valid", 64'(resp_valid), 64'd1);
            chk("rd_miss_data", resp_rdata, d);
            chk("rd_miss_flag", 64'(miss), 64'd1);
            chk("rd_miss_ready", 64'(req_ready), inv_wait ? 64'd0 : 64'd1);
            exp_miss++;
            mv[ix(a)] = 1'b1;
            ma[ix(a)] = w;
            if (inv_wait) begin
                @(negedge clk);
                inv_all = 1'b0;
                model_clear();
            end
        end
        chk_counts();
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input int rdly);
        logic [63:0] w;
        bit h;
        w = al(a);
        h = m_hit(a);
        @(negedge clk);
        req_write = 1'b1;
        req_addr = a;
        req_wdata = d;
        #1 chk("wr_accept_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_write = 1'b0;
        chk("wr_mreq_valid", 64'(mem_req_valid), 64'd1);
        chk("wr_mreq_we", 64'(mem_req_we), 64'd1);
        chk("wr_mreq_addr", mem_req_addr, w);
        chk("wr_mreq_wdata", mem_req_wdata, d);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("wr_hold_wdata", mem_req_wdata, d);
            chk("wr_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("wr_hold_resp", 64'(resp_valid), 64'd0);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("wr_resp_valid", 64'(resp_valid), 64'd1);
        chk("wr_resp_miss", 64'(miss), h ? 64'd0 : 64'd1);
        chk("wr_resp_rdata", resp_rdata, 64'd0);
        chk("wr_resp_ready", 64'(req_ready), 64'd1);
        mem[w] = d;
        if (h) exp_hits++;
        else exp_miss++;
        chk_counts();
    endtask

    initial begin
        logic [63:0] ra;
        model_clear();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mreq_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mreq_addr", mem_req_addr, 64'd0);
        chk_counts();
        rst_n = 1'b1;

        mem[64'h100] = 64'hDEAD_BEEF;
        do_read(64'h100, 0, 0, 0);
        do_read(64'h100, 0, 0, 0);
        do_write(64'h100, 64'h1234, 0);
        do_read(64'h100, 0, 0, 0);
        do_write(64'h200, 64'h5555_AAAA, 1);
        do_read(64'h200, 1, 1, 0);

        do_read(64'h008, 0, 1, 0);
        do_read(64'h088, 0, 0, 0);
        do_read(64'h008, 0, 0, 0);

        do_read(64'h300, 5, 2, 0);

        @(negedge clk);
        req_read = 1'b1;
        req_addr = 64'h008;
        @(negedge clk);
        chk("b2b_valid0", 64'(resp_valid), 64'd1);
        chk("b2b_data0", resp_rdata, mem[64'h008]);
        chk("b2b_ready", 64'(req_ready), 64'd1);
        req_addr = 64'h300;
        @(negedge clk);
        req_read = 1'b0;
        chk("b2b_valid1", 64'(resp_valid), 64'd1);
        chk("b2b_data1", resp_rdata, mem[64'h300]);
        exp_hits += 2;
        chk_counts();

        do_read(64'h010, 0, 0, 0);
        do_read(64'h018, 0, 0, 0);
        @(negedge clk);
        inv_all = 1'b1;
        req_read = 1'b1;
        req_addr = 64'h010;
        #1 chk("inv_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        inv_all = 1'b0;
        req_read = 1'b0;
        chk("inv_no_resp", 64'(resp_valid), 64'd0);
        model_clear();
        do_read(64'h008, 0, 0, 0);
        do_read(64'h010, 0, 0, 0);
        do_read(64'h018, 0, 0, 0);

        do_read(64'h020, 1, 2, 1);
        do_read(64'h020, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            ra = (64'($urandom_range(0, 3)) << 7) | (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) do_write(ra, {$urandom, $urandom}, $urandom_range(0, 3));
            else do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        @(negedge clk);
        req_read = 1'b1;
        req_addr = 64'h400;
        @(negedge clk);
        req_read = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp", 64'(resp_valid), 64'd0);
        chk("mid_rst_mreq", 64'(mem_req_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_addr", mem_req_addr, 64'd0);
        chk("mid_rst_hits", 64'(hit_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD0_BAD0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("spur_resp", 64'(resp_valid), 64'd0);
        model_clear();
        exp_hits = 0;
        exp_miss = 0;
        chk_counts();
        do_read(64'h400, 0, 0, 0);
        do_read(64'h400, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_dm.md
# dcache_dm

Direct-mapped, write-through, no-write-allocate L1 data cache sitting directly downstream of the load/store buffer. It consumes the buffer's one-request-at-a-time memory port (read/write, address, write data) and returns read data plus a hit/miss indication. Misses and all writes go to the external memory bus over a valid/ready request channel, and read misses receive their fill on a separate response channel.

## Interface
Parameters:
- LINES, 16: number of lines, power of two ≥ 2; one 64-bit word per line.
- IDX_W, $clog2(LINES): index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_read  in  1  load request from the buffer.
- req_write  in  1  store request; if both are set, it is treated as a write.
- req_addr  in  64  byte address; bits [2:0] are ignored.
- req_wdata  in  64  store data.
- req_ready  out  1  request is accepted in any cycle with (req_read|req_write) && req_ready.
- resp_valid  out  1  one-cycle pulse completing the accepted request.
- resp_rdata  out  64  load data, valid with resp_valid on reads; 0 for writes.
- miss  out  1  valid with resp_valid; 1 means the lookup missed.
- inv_all  in  1  invalidate every line.
- mem_req_valid  out  1  external request valid.
- mem_req_ready  in  1  external request accepted.
- mem_req_we  out  1  1 means write.
- mem_req_addr  out  64  word-aligned address, with bits [2:0] forced to 0.
- mem_req_wdata  out  64  write data.
- mem_resp_valid  in  1  read fill valid.
- mem_resp_rdata  in  64  fill data.
- hit_count, miss_count  out  32  saturating statistics counters.

## Operation
- Address split: index = addr[3+IDX_W-1:3], tag = addr[63:3+IDX_W].
- Per-line storage: valid bit, tag, data. hit = valid[index] && tag match.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- req_ready = (state==IDLE) && !inv_all.
- Read hit in IDLE:
  - State stays IDLE.
  - Registered resp_valid with resp_rdata = line data, miss=0.
  - hit_count increments.
- Read miss in IDLE:
  - Latch the address and go to RD_REQ.
  - RD_REQ: mem_req_valid=1, we=0; on mem_req_ready go to RD_WAIT.
  - RD_WAIT: on mem_resp_valid, write the line (valid=1, tag, data) and return to IDLE.
  - Registered resp_valid carries the fill data with miss=1; miss_count increments.
- Write in IDLE:
  - Latch address and data; record hit.
  - On hit, update line data at the acceptance edge. On miss, leave the array unchanged (no allocate).
  - Go to WR_REQ: mem_req_valid=1, we=1, address and data from the latches.
  - On mem_req_ready, return to IDLE and pulse resp_valid with miss = !hit. The matching counter increments.
  - Writes are posted: no mem_resp is expected.
- mem_resp_valid outside RD_WAIT is ignored.
- inv_all:
  - In IDLE, clears all valid bits at the next edge; no request is accepted that cycle.
  - In other states, it is held off until IDLE.
- mem_req_* outputs are held stable while mem_req_valid && !mem_req_ready.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - All valid bits are 0 and state is IDLE.
  - resp_valid, miss and mem_req_valid are 0.
  - resp_rdata, mem_req_addr, mem_req_wdata, mem_req_we and both counters are 0.
  - req_ready is 1, since it follows IDLE && !inv_all.
- Reset mid-miss or mid-write aborts the transaction; no resp_valid is produced.
- Read hit accepted at cycle T: resp_valid at T+1. Back-to-back hits sustain one per cycle.
- Read miss accepted at T: mem_req_valid from T+1. If mem_resp_valid arrives at R, resp_valid occurs at R+1 and req_ready=1 at R+1.
- Write accepted at T: mem_req_valid from T+1. If the handshake completes at W, resp_valid occurs at W+1 and req_ready=1 at W+1.
- Minimum miss latency is 3 cycles (ready at T+1, response at T+2, resp_valid at T+3).
- A read hit to a line written at T-1 returns the new data, because the array is written at the edge ending T-1.

## Structure
- Package dcache_pkg holds: state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ), the word-offset constant 3, and index/tag extraction functions parameterised by IDX_W.
- Sub-module dcache_dm_array holds the valid/tag/data storage:
  - Combinational read port indexed by index.
  - One write port.
  - Single-cycle invalidate-all.
- The top level holds the FSM, latches, counters and the response register.

## Test plan
- Reset, then read 0x100: miss; mem_req_addr=0x100, we=0. Fill 0xDEAD_BEEF → resp_rdata=0xDEAD_BEEF, miss=1. Read 0x100 again → hit at T+1, miss=0, hit_count=1.
- Write 0x100 with 0x1234 after it is cached: one mem write request, resp miss=0. Read 0x100 at the next cycle → 0x1234 on a hit. Write to uncached 0x200 → miss=1, and a later read of 0x200 still misses.
- Conflict: with LINES=16, fill 0x008, then read 0x088 (same index 1, different tag) → miss evicts the line. Read 0x008 → misses again.
- Backpressure: hold mem_req_ready=0 for 5 cycles during a read miss. The mem_req_* outputs stay stable, req_ready=0 throughout, and exactly one resp_valid follows.
- inv_all while in IDLE with 3 lines cached → req_ready=0 that cycle, and all three addresses subsequently miss. inv_all during RD_WAIT → the fill completes first, then the invalidate takes effect.
- Assert rst_n=0 during RD_WAIT → no resp_valid, all outputs at reset values. A spurious mem_resp_valid after reset is ignored.
